stage_wb_skid: RTL and testbench
================================

STAGE_WB_SKID -- requirements
Module: stage_wb_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of the memory-data and ALU-result (busc) payloads.
REQ-002 Parameter RD_W, default 5, destination-register index width.
REQ-003 Parameter WRN_W, default 2, writeback-select width.
REQ-004 Parameter SKID, default 1; 1 = two-entry skid buffer, 0 = single register with combinational back-pressure.
REQ-005 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 Port flush  input  1  synchronous discard of all held entries.
REQ-008 Port in_valid  input  1  upstream beat present.
REQ-009 Port in_ready  output  1  stage accepts a beat this cycle.
REQ-010 Port in_data  input  DATA_W  memory read data.
REQ-011 Port in_busc  input  DATA_W  ALU result.
REQ-012 Port in_rd  input  RD_W  destination register index.
REQ-013 Port in_we  input  1  register-file write request.
REQ-014 Port in_wrn  input  WRN_W  writeback source select.
REQ-015 Port out_valid  output  1  head entry present.
REQ-016 Port out_ready  input  1  downstream consumes the head entry.
REQ-017 Ports out_data, out_busc, out_rd, out_wrn  output  DATA_W, DATA_W, RD_W, WRN_W  head entry fields.
REQ-018 Port out_we  output  1  qualified register-file write.
REQ-019 Port occ  output  2  number of held entries (0..2; 0..1 when SKID=0).

Function
REQ-020 Accept = in_valid & in_ready; drain = out_valid & out_ready; both evaluated in the same cycle.
REQ-021 SKID=1: in_ready SHALL be registered, equal to !skid_valid, with no combinational path from out_ready.
REQ-022 SKID=1: an accepted beat SHALL load the head slot if the head is empty or draining, else the skid slot.
REQ-023 SKID=1: on drain with skid_valid=1, the skid entry SHALL move to the head slot in the same edge; an accept in that cycle lands in skid.
REQ-024 SKID=0: in_ready = !head_valid | out_ready (combinational); the skid slot does not exist.
REQ-025 Latency: an accepted beat SHALL appear on out_* in the next cycle when the stage was empty; order is strictly FIFO.
REQ-026 out_valid SHALL equal head_valid; out_* hold stable while out_valid & !out_ready.
REQ-027 out_we = head_valid & head_we & (head_rd != 0); writes to x0 SHALL be suppressed.
REQ-028 flush SHALL clear head_valid and skid_valid at the next edge, overriding any simultaneous accept or move; in_ready = 1 the following cycle.
REQ-029 Payload fields of invalid slots SHALL NOT be updated (power; no X propagation).
REQ-030 occ SHALL be head_valid + skid_valid, registered; it never exceeds 2, and the stage never accepts at occ=2.

Reset
REQ-031 rst_n low SHALL immediately clear both valid bits and zero all payload registers, giving out_valid=0, out_we=0, occ=0, out_* = 0.
REQ-032 While rst_n is low, in_ready SHALL be 0; it SHALL go to 1 at the first edge after deassertion.
REQ-033 Reset mid-transfer SHALL discard all held entries without emitting them.

Structure
REQ-034 Shared package stage_pkg SHALL hold the default widths and the WRN_W encodings (WRN_MEM=2'b00, WRN_ALU=2'b01, WRN_PC4=2'b10).
REQ-035 One sub-module stage_slot (valid bit plus payload register with load and clear) SHALL be instantiated for head and, under SKID=1, for skid.

Verification
REQ-036 Reset: rst_n=0 for 3 cycles, then release -> occ=0, out_valid=0, out_we=0 throughout; in_ready=1 one cycle after release.
REQ-037 Streaming: SKID=1, out_ready=1, 8 back-to-back beats busc=1..8 -> out_busc 1..8 in order, one per cycle, one-cycle latency, in_ready constantly 1.
REQ-038 Back-pressure: SKID=1, out_ready=0, push busc=0xA, 0xB, 0xC -> first two accepted, occ=2, in_ready=0, 0xC held upstream; out_ready=1 -> 0xA, 0xB, 0xC emerge in order.
REQ-039 x0 suppression: beat in_we=1, in_rd=0 -> out_valid=1, out_we=0; beat in_we=1, in_rd=5 -> out_we=1.
REQ-040 Flush: occ=2 and flush=1 with in_valid=1 -> next cycle occ=0, out_valid=0, and the concurrent beat is not emitted.
REQ-041 SKID=0: out_ready=0 with head full -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> accept and drain in the same cycle, occ stays 1.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared widths and writeback-select encodings for the writeback skid stage.
package stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RD_W_DEF   = 5;
    localparam int WRN_W_DEF  = 2;

    localparam logic [1:0] WRN_MEM = 2'b00;
    localparam logic [1:0] WRN_ALU = 2'b01;
    localparam logic [1:0] WRN_PC4 = 2'b10;

    // Packed slot payload: {data, busc, rd, we, wrn}
    function automatic int slot_w(input int dw, input int rw, input int ww);
        return 2 * dw + rw + 1 + ww;
    endfunction

endpackage

// File: rtl/stage_slot.sv
// One pipeline slot: a valid bit plus a payload register that only loads with a valid beat.
module stage_slot
    import stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic         o_valid,
    output logic [W-1:0] o_q
);

    logic         r_valid;
    logic [W-1:0] r_q;

    // Clear wins over load so a flush discards a concurrent fill; payload is
    // left untouched on clear to avoid needless toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_q     <= i_d;
        end
    end

    assign o_valid = r_valid;
    assign o_q     = r_q;

endmodule

// File: rtl/stage_wb_skid.sv
// Writeback-stage pipeline register with optional two-entry skid buffer.
module stage_wb_skid
    import stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int WRN_W  = WRN_W_DEF,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_busc,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_we,
    input  logic [WRN_W-1:0]  in_wrn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_busc,
    output logic [RD_W-1:0]   out_rd,
    output logic [WRN_W-1:0]  out_wrn,
    output logic              out_we,
    output logic [1:0]        occ
);

    localparam int PW = slot_w(DATA_W, RD_W, WRN_W);

    logic [PW-1:0] w_in_pay, w_head_d, w_head_q, w_skid_q;
    logic          w_head_v, w_skid_v, w_head_we;
    logic          w_acc, w_drn, w_head_free;
    logic          w_head_load, w_head_clear, w_skid_load, w_skid_clear;
    logic          w_head_nxt, w_skid_nxt;
    logic          r_in_ready;
    logic [1:0]    r_occ;

    assign w_in_pay = {in_data, in_busc, in_rd, in_we, in_wrn};

    always_comb begin
        w_acc        = in_valid & in_ready;
        w_drn        = w_head_v & out_ready;
        w_head_free  = !w_head_v | w_drn;
        // Head refills from skid first to keep FIFO order; a new beat only
        // goes straight to head when nothing is waiting in skid.
        w_head_load  = !flush & ((w_drn & w_skid_v) | (w_head_free & !w_skid_v & w_acc));
        w_head_d     = w_skid_v ? w_skid_q : w_in_pay;
        w_head_clear = flush | (w_drn & !w_head_load);
        w_skid_load  = !flush & w_acc & !(w_head_free & !w_skid_v);
        w_skid_clear = flush | (w_drn & w_skid_v & !w_skid_load);
        w_head_nxt   = !flush & (w_head_load | (w_head_v & !w_drn));
        w_skid_nxt   = !flush & (w_skid_load | (w_skid_v & !w_drn));
    end

    stage_slot #(.W(PW)) u_head (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_head_load),
        .i_clear (w_head_clear),
        .i_d     (w_head_d),
        .o_valid (w_head_v),
        .o_q     (w_head_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            stage_slot #(.W(PW)) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_d     (w_in_pay),
                .o_valid (w_skid_v),
                .o_q     (w_skid_q)
            );

            // Registered ready: no path from out_ready to in_ready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_in_ready <= 1'b0;
                else        r_in_ready <= !w_skid_nxt;
            end

            assign in_ready = r_in_ready;
        end else begin : g_noskid
            assign w_skid_v = 1'b0;
            assign w_skid_q = '0;

            // Here the register only marks "out of reset" so ready stays low in reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_in_ready <= 1'b0;
                else        r_in_ready <= 1'b1;
            end

            assign in_ready = r_in_ready & (!w_head_v | out_ready);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_occ <= 2'd0;
        else        r_occ <= {1'b0, w_head_nxt} + {1'b0, w_skid_nxt};
    end

    assign {out_data, out_busc, out_rd, w_head_we, out_wrn} = w_head_q;
    assign out_valid = w_head_v;
    assign out_we    = w_head_v & w_head_we & (|out_rd);
    assign occ       = r_occ;

endmodule

// File: tb/tb_stage_wb_skid.sv
// Scoreboard bench: drives one SKID=1 and one SKID=0 instance with the same stimulus.
module tb_stage_wb_skid;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] busc;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  wrn;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [31:0] in_busc = '0;
    logic [4:0]  in_rd = '0;
    logic        in_we = 1'b0;
    logic [1:0]  in_wrn = '0;
    logic        out_ready = 1'b0;

    logic [1:0]  i_rdy, o_vld, o_we;
    logic [31:0] o_data [2];
    logic [31:0] o_busc [2];
    logic [4:0]  o_rd   [2];
    logic [1:0]  o_wrn  [2];
    logic [1:0]  o_occ  [2];

    int   vectors = 0;
    int   miscompares = 0;
    pay_t mq [2][$];
    bit   rdy_en [2] = '{0, 0};

    always #5 clk = ~clk;

    stage_wb_skid #(.DATA_W(32), .RD_W(5), .WRN_W(2), .SKID(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(i_rdy[1]),
        .in_data(in_data), .in_busc(in_busc), .in_rd(in_rd), .in_we(in_we), .in_wrn(in_wrn),
        .out_valid(o_vld[1]), .out_ready(out_ready),
        .out_data(o_data[1]), .out_busc(o_busc[1]), .out_rd(o_rd[1]), .out_wrn(o_wrn[1]),
        .out_we(o_we[1]), .occ(o_occ[1])
    );

    stage_wb_skid #(.DATA_W(32), .RD_W(5), .WRN_W(2), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(i_rdy[0]),
        .in_data(in_data), .in_busc(in_busc), .in_rd(in_rd), .in_we(in_we), .in_wrn(in_wrn),
        .out_valid(o_vld[0]), .out_ready(out_ready),
        .out_data(o_data[0]), .out_busc(o_busc[0]), .out_rd(o_rd[0]), .out_wrn(o_wrn[0]),
        .out_we(o_we[0]), .occ(o_occ[0])
    );

    task automatic cmp(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s skid=%0d t=%0t got=%0h want=%0h", name, k, $time, act, exp);
        end
    endtask

    // Reference: each instance is a FIFO of accepted beats, capacity 2 with
    // SKID and 1 without; flush and reset empty it.
    task automatic check(input int k);
        int   n;
        bit   er;
        pay_t h, cur;
        n = mq[k].size();
        if (!rst_n) begin
            cmp("rst_in_ready", k, 64'(i_rdy[k]), 64'd0);
            cmp("rst_out_valid", k, 64'(o_vld[k]), 64'd0);
            cmp("rst_out_we", k, 64'(o_we[k]), 64'd0);
            cmp("rst_occ", k, 64'(o_occ[k]), 64'd0);
            cmp("rst_payload", k, 64'(|{o_data[k], o_busc[k], o_rd[k], o_wrn[k]}), 64'd0);
            mq[k].delete();
            rdy_en[k] = 0;
            return;
        end
        er = rdy_en[k] && ((k == 1) ? (n < 2) : (n == 0 || out_ready));
        cmp("in_ready", k, 64'(i_rdy[k]), 64'(er));
        cmp("out_valid", k, 64'(o_vld[k]), 64'(n > 0));
        cmp("occ", k, 64'(o_occ[k]), 64'(n));
        if (n > 0) begin
            h = mq[k][0];
            cmp("out_busc", k, 64'(o_busc[k]), 64'(h.busc));
            cmp("out_data", k, 64'(o_data[k]), 64'(h.data));
            cmp("out_rd", k, 64'(o_rd[k]), 64'(h.rd));
            cmp("out_wrn", k, 64'(o_wrn[k]), 64'(h.wrn));
            cmp("out_we", k, 64'(o_we[k]), 64'(h.we && h.rd != 0));
            if (out_ready) void'(mq[k].pop_front());
        end else begin
            cmp("out_we_idle", k, 64'(o_we[k]), 64'd0);
        end
        if (in_valid && er) begin
            cur = '{data: in_data, busc: in_busc, rd: in_rd, we: in_we, wrn: in_wrn};
            mq[k].push_back(cur);
        end
        if (flush) mq[k].delete();
        rdy_en[k] = 1;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) check(k);
    end

    task automatic drive(input bit v, input logic [31:0] busc, input logic [4:0] rd,
                         input bit we, input bit ordy, input bit fl);
        in_valid  = v;
        in_busc   = busc;
        in_data   = $urandom;
        in_rd     = rd;
        in_we     = we;
        in_wrn    = 2'($urandom_range(0, 2));
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int orate;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);

        // streaming
        for (int i = 1; i <= 8; i++) drive(1, 32'(i), 5'($urandom_range(1, 31)), 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0);

        // back-pressure: C held upstream until space frees
        drive(1, 32'hA, 5'd3, 1, 0, 0);
        drive(1, 32'hB, 5'd4, 1, 0, 0);
        drive(1, 32'hC, 5'd6, 1, 0, 0);
        drive(1, 32'hC, 5'd6, 1, 0, 0);
        drive(1, 32'hC, 5'd6, 1, 1, 0);
        drive(1, 32'hC, 5'd6, 1, 1, 0);
        repeat (4) drive(0, 0, 0, 0, 1, 0);

        // x0 suppression
        drive(1, 32'h11, 5'd0, 1, 1, 0);
        drive(1, 32'h22, 5'd5, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0);

        // flush at full occupancy with a concurrent beat
        drive(1, 32'h31, 5'd7, 1, 0, 0);
        drive(1, 32'h32, 5'd8, 1, 0, 0);
        drive(1, 32'h33, 5'd9, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);

        // randomized traffic with flushes and occasional mid-stream reset
        for (int blk = 0; blk < 30; blk++) begin
            orate = $urandom_range(10, 100);
            for (int c = 0; c < 100; c++) begin
                if ($urandom_range(0, 399) == 0) begin
                    rst_n = 1'b0;
                    drive(0, 0, 0, 0, 1, 0);
                    drive(1, 32'hDEAD, 5'd1, 1, 1, 0);
                    rst_n = 1'b1;
                end
                drive($urandom_range(0, 9) < 7, $urandom,
                      ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                      1'($urandom), $urandom_range(1, 100) <= orate,
                      $urandom_range(0, 49) == 0);
            end
        end
        repeat (4) drive(0, 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
